// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared state encoding and constants for the program loader
package instr_loader_pkg;

  typedef enum logic [2:0] {IDLE, LEN, LOAD, CHK, DONE, ERR} loader_state_t;

  localparam int LEN_BYTES = 4;

endpackage

// File: rtl/byte_shift_le.sv
// rtl/byte_shift_le.sv - little-endian byte assembler: first byte in lands in bits [7:0]
module byte_shift_le
  import instr_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   shift,
  input  logic [7:0]             data,
  output logic [8*LEN_BYTES-1:0] value,
  output logic [8*LEN_BYTES-1:0] next_value,
  output logic [2:0]             count
);

  // Bytes enter at the top and move down, so after LEN_BYTES shifts byte 0 is the LSB.
  assign next_value = {data, value[8*LEN_BYTES-1:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (shift) begin
      value <= next_value;
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream program loader; INSTR_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       MEM_ADDR_BITS = 12,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [7:0]               wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     cpu_rst,
  output logic [MEM_ADDR_BITS:0]   byte_count
);

  localparam int               LW      = 8 * LEN_BYTES;
  localparam logic [LW-1:0]    MAX_LEN = LW'(1) << MEM_ADDR_BITS;

  loader_state_t           state, next_state;
  logic                    session_start;
  logic                    shift_en;
  logic [LW-1:0]           len_value;
  logic [LW-1:0]           len_next;
  logic [2:0]              len_count;
  logic [MEM_ADDR_BITS:0]  count_next;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]              csum;
  localparam loader_state_t AFTER_PAYLOAD = CHK;
`else
  localparam loader_state_t AFTER_PAYLOAD = DONE;
`endif

  assign count_next = byte_count + 1'b1;

  byte_shift_le u_len (
    .clk        (clk),
    .rst        (rst),
    .clear      (session_start),
    .shift      (shift_en),
    .data       (byte_data),
    .value      (len_value),
    .next_value (len_next),
    .count      (len_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    byte_ready    = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    cpu_rst       = 1'b1;
    session_start = 1'b0;
    shift_en      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state    = LEN;
          session_start = 1'b1;
        end
      end
      LEN: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        shift_en   = byte_valid;
        if (byte_valid && len_count == 3'(LEN_BYTES - 1)) begin
          if (len_next == '0) begin
            next_state = AFTER_PAYLOAD;
          end else if (len_next > MAX_LEN) begin
            next_state = ERR;
          end else begin
            next_state = LOAD;
          end
        end
      end
      LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        // Length was already bounded to MAX_LEN, so its low bits hold it exactly.
        if (byte_valid && count_next == len_value[MEM_ADDR_BITS:0]) begin
          next_state = AFTER_PAYLOAD;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      CHK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          next_state = (byte_data == csum) ? DONE : ERR;
        end
      end
`endif
      DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (start) begin
          next_state    = LEN;
          session_start = 1'b1;
        end
      end
      ERR: begin
        error = 1'b1;
        if (start) begin
          next_state    = LEN;
          session_start = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Write port is registered: a payload byte accepted on this edge is written on the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= 8'h00;
      byte_count <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      wr_en <= 1'b0;
      if (session_start) begin
        byte_count <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum       <= 8'h00;
`endif
      end else if (state == LOAD && byte_valid) begin
        wr_en      <= 1'b1;
        wr_addr    <= BASE_ADDR + ADDRESS_WIDTH'(byte_count);
        wr_data    <= byte_data;
        byte_count <= count_next;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum       <= csum ^ byte_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized self-checking bench for instr_loader (honours INSTR_LOADER_CHECKSUM_EN)
module tb_instr_loader;

  localparam int          AW       = 32;
  localparam int          MB       = 12;
  localparam int          MEM_SIZE = 1 << MB;
  localparam logic [31:0] BASE     = 32'h0000_2000;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_rst;
  logic [MB:0]   byte_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] obs_mem [MEM_SIZE];

  instr_loader #(.ADDRESS_WIDTH(AW), .MEM_ADDR_BITS(MB), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_rst    (cpu_rst),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // Stream = 4 length bytes (LE), payload, and the XOR checksum when that feature is built.
  function automatic bq_t make_stream(input logic [31:0] len, input int n_pay, input bit corrupt);
    bq_t        s;
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) s.push_back(len[8*i +: 8]);
    for (int i = 0; i < n_pay; i++) begin
      b = 8'($urandom);
      x ^= b;
      s.push_back(b);
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (len <= MEM_SIZE) s.push_back(corrupt ? (x ^ 8'h5A) : x);
`else
    if (corrupt) s.push_back(x);
`endif
    return s;
  endfunction

  // mode 0: valid held high; 1: valid toggles 1/0; 2: valid random
  task automatic run_session(input string name, input bq_t stream, input int mode, input bit poke_start);
    logic [31:0] lenv;
    int          n_pay, idx, cycles, limit, writes, bad_wr, lat_errs, img_err;
    bit          exp_done, acc, exp_wr;
    logic [7:0]  x;
    lenv  = {stream[3], stream[2], stream[1], stream[0]};
    n_pay = (lenv <= MEM_SIZE) ? int'(lenv) : 0;
    if (lenv > MEM_SIZE) exp_done = 1'b0;
    else begin
`ifdef INSTR_LOADER_CHECKSUM_EN
      x = 8'h00;
      for (int k = 0; k < n_pay; k++) x ^= stream[4+k];
      exp_done = (stream[4+n_pay] == x);
`else
      x = 8'h00;
      exp_done = 1'b1;
`endif
    end
    for (int k = 0; k < MEM_SIZE; k++) obs_mem[k] = 8'hxx;
    idx = 0; cycles = 0; writes = 0; bad_wr = 0; lat_errs = 0; img_err = 0;
    limit = 4 * stream.size() + 100;

    start = 1'b1; byte_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if ({busy, cpu_rst, done, error, wr_en} !== 5'b11000 || byte_count !== 0)
      $display("FAIL %s start_entry: busy/cpu_rst/done/error/wr_en=%b count=%0d, required 11000 count=0",
               name, {busy, cpu_rst, done, error, wr_en}, byte_count);
    else n_pass++;

    while (busy === 1'b1 && cycles < limit) begin
      byte_valid = (idx < stream.size()) &&
                   (mode == 0 || (mode == 1 && cycles % 2 == 0) || (mode == 2 && $urandom_range(1) == 1));
      byte_data  = byte_valid ? stream[idx] : 8'($urandom);
      start      = poke_start && ($urandom_range(7) == 0);
      acc        = byte_valid && byte_ready;
      exp_wr     = acc && idx >= 4 && idx < 4 + n_pay;
      @(posedge clk); #1;
      cycles++;
      if (wr_en !== exp_wr) lat_errs++;
      if (wr_en === 1'b1) begin
        if (wr_addr !== BASE + 32'(writes)) bad_wr++;
        if (writes < MEM_SIZE) obs_mem[writes] = wr_data;
        writes++;
      end
      if (acc) idx++;
    end
    start = 1'b0; byte_valid = 1'b0;
    for (int k = 0; k < n_pay; k++) if (obs_mem[k] !== stream[4+k]) img_err++;

    n_checks++;
    if (cycles >= limit) $display("FAIL %s timeout: busy still %b after %0d cycles, required session end", name, busy, cycles);
    else n_pass++;
    n_checks++;
    if (lat_errs != 0) $display("FAIL %s write_timing: %0d cycles with wrong wr_en, required 0", name, lat_errs);
    else n_pass++;
    n_checks++;
    if (writes != n_pay || bad_wr != 0)
      $display("FAIL %s writes: count=%0d bad_addr=%0d, required count=%0d bad_addr=0", name, writes, bad_wr, n_pay);
    else n_pass++;
    n_checks++;
    if (img_err != 0) $display("FAIL %s image: %0d wrong bytes, required 0", name, img_err);
    else n_pass++;
    n_checks++;
    if ({done, error, cpu_rst, busy, byte_ready} !== {exp_done, !exp_done, !exp_done, 2'b00})
      $display("FAIL %s status: done/error/cpu_rst/busy/ready=%b, required %b", name,
               {done, error, cpu_rst, busy, byte_ready}, {exp_done, !exp_done, !exp_done, 2'b00});
    else n_pass++;
    n_checks++;
    if (byte_count !== (MB+1)'(n_pay)) $display("FAIL %s byte_count: got %0d, required %0d", name, byte_count, n_pay);
    else n_pass++;
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if ({byte_ready, wr_en, busy, done, error, cpu_rst} !== 6'b000001 || wr_addr !== BASE ||
        wr_data !== 8'h00 || byte_count !== 0)
      $display("FAIL %s: ready/wr_en/busy/done/error/cpu_rst=%b addr=%h data=%h count=%0d, required 000001 addr=%h data=00 count=0",
               name, {byte_ready, wr_en, busy, done, error, cpu_rst}, wr_addr, wr_data, byte_count, BASE);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 check_reset_values("reset_hold");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset_idle");
  endtask

  task automatic test_basic();
    bq_t s;
    s = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
`ifdef INSTR_LOADER_CHECKSUM_EN
    s.push_back(8'hC3);
`endif
    run_session("basic", s, 0, 1'b0);
    run_session("gapped", s, 1, 1'b0);
  endtask

  task automatic test_length_bounds();
    run_session("zero_len", make_stream(32'd0, 0, 1'b0), 0, 1'b0);
    run_session("overflow", make_stream(32'd4097, 0, 1'b0), 0, 1'b0);
    run_session("max_len", make_stream(32'd4096, 4096, 1'b0), 0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(64, 1);
      run_session($sformatf("random%0d", r), make_stream(32'(n), n, 1'b0), 2, 1'b1);
    end
  endtask

  task automatic test_reset_mid_load();
    bq_t s;
    s = make_stream(32'd8, 8, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      byte_valid = 1'b1; byte_data = s[i];
      @(posedge clk); #1;
    end
    rst = 1'b1; byte_valid = 1'b0;
    #1 check_reset_values("reset_mid_load");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_values("after_mid_reset");
    run_session("reload", s, 0, 1'b0);
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bq_t s;
    s = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
    run_session("csum_good", s, 0, 1'b0);
    s = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h00};
    run_session("csum_bad", s, 0, 1'b0);
    run_session("csum_rand_bad", make_stream(32'd20, 20, 1'b1), 2, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_length_bounds();
    test_random();
    test_reset_mid_load();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
